// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: machine width, instruction size
// and the fetch entry that pairs an instruction word with its PC.
package mips_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a flush that empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is not reset; consumers qualify the head with o_empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_push |-> (r_count != CW'(DEPTH)));
endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch: owns the PC, issues credit-limited requests to a
// variable-latency memory, and queues responses for decode. Redirects flush everything.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic            r_run;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_count;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic [CW:0]     w_inflight;
    logic [CW-1:0]   w_out_after_rsp;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_req_fire;
    logic            w_rsp_drop;
    logic            w_push;
    logic            w_pop;

    // Credit uses registered occupancy only, so a pop frees its slot one cycle later.
    assign w_inflight     = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_valid = r_run && !redirect_valid && (w_inflight < CREDITS);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_redirect_pc   = redirect_pc & ~32'h3;
    assign w_rsp_drop      = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_push          = imem_rsp_valid && !w_rsp_drop && !redirect_valid;
    assign w_pop           = instr_valid && instr_ready && !redirect_valid;
    assign w_out_after_rsp = r_outstanding - CW'(imem_rsp_valid);

    // Responses return in order, so the next kept response always belongs to r_rsp_pc.
    assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

    assign instr_valid = !w_empty;
    assign instr       = w_empty ? '0 : w_head.instr;
    assign instr_pc    = w_empty ? '0 : w_head.pc;

    sync_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(DEPTH)
    ) u_queue (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_flush(redirect_valid),
        .i_push (w_push),
        .i_data (w_push_entry),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_empty(w_empty),
        .o_count(w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc    <= w_redirect_pc;
                r_rsp_pc      <= w_redirect_pc;
                r_outstanding <= w_out_after_rsp;
                r_drop_cnt    <= w_out_after_rsp;
            end else begin
                if (w_req_fire) r_fetch_pc <= next_pc(r_fetch_pc);
                if (w_push)     r_rsp_pc   <= next_pc(r_rsp_pc);
                r_outstanding <= w_out_after_rsp + CW'(w_req_fire);
                if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (r_outstanding != '0));
    a_drop_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        r_drop_cnt <= r_outstanding);
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the MIPS core. Owns the program counter and issues word requests to a variable-latency instruction memory.
- Buffers returned instructions in a small prefetch queue and presents them, with their PC, to the decode/register-file stage over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from downstream; a redirect flushes buffered and in-flight fetches.

Parameters:
- DEPTH, 4, prefetch queue entries; also the maximum of (queued + outstanding) requests; power of two, 2..16
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  word-aligned fetch address
- imem_rsp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance
- imem_rsp_data  input  32  instruction word
- instr_valid  output  1  queue head valid to decode
- instr_ready  input  1  decode consumes head
- instr  output  32  head instruction
- instr_pc  output  32  PC of head instruction
- redirect_valid  input  1  redirect this cycle
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (treated as 0)

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0; imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC, instr=0, instr_pc=0.
- Credit rule: imem_req_valid = !redirect_valid && (count + outstanding < DEPTH). The credit uses registered state only; a same-cycle pop does not free a credit until the next cycle.
- imem_req_addr = fetch_pc. On handshake (valid && ready): fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0) and outstanding += 1.
- Each queue entry holds {pc, data}. A tag FIFO of request PCs (DEPTH deep, the same storage) pairs responses with PCs in order.
- Response: if drop_cnt > 0, discard and decrement drop_cnt. Otherwise push {pc, data}. The push can never overflow, by the credit rule. outstanding -= 1 in both cases.
- Pop on instr_valid && instr_ready. instr and instr_pc are driven from the queue head (registered storage, no bypass): there is minimum 1 cycle from rsp to instr_valid.
- Simultaneous push and pop: count unchanged.
- Redirect cycle has priority over all other events:
  - Queue cleared; any pop that cycle is ignored by the unit.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding_after_this_cycle, i.e. outstanding minus any response arriving this cycle. That response is itself dropped.
  - No request is issued.
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- instr_valid=0 in the cycle after a redirect, until a post-redirect response is pushed.
- Stall: with instr_ready=0, the queue fills and requests stop at count+outstanding=DEPTH; no data loss.
- Invariants: count + outstanding <= DEPTH; drop_cnt <= outstanding.
- Optional assertions: rsp_valid with outstanding==0 is an error; push when full is an error.

Decomposition:
- Shared package mips_pkg:
  - XLEN=32 and INSTR_BYTES=4 constants
  - a typedef for the fetch entry {pc[31:0], instr[31:0]}
- One natural sub-module: sync_fifo (parameterised width/depth, count output, flush input), instantiated once for the prefetch/tag queue.
- Counter and credit logic stay in instr_fetch_unit.

Test Plan:
- Reset, memory always ready with 1-cycle latency, decode always ready -> instr_pc sequence 0x0,0x4,0x8,0xC,... one per cycle in steady state; instr equals the memory model word at each PC.
- instr_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests issued (0x0..0xC); imem_req_valid=0 afterwards. On release, 4 pops in order, then fetch resumes at 0x10.
- Memory latency 3, redirect to 0x100 while 2 requests are outstanding -> both late responses are dropped; the next instr_pc seen is 0x100, then 0x104.
- Redirect to 0x203 in the same cycle as a response and a pop -> the response is discarded; the next fetch address is 0x200; queue empty the following cycle.
- Redirect to 0xFFFF_FFF8 -> instr_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert rst_n low mid-stream with requests outstanding -> outputs return to reset values immediately (async). After release, fetch restarts at RESET_PC; the bench memory model is also reset.
